pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter with valid/ready handshakes on both sides. It supports logical left/right shift, arithmetic right shift, and left/right rotate, and reports a sticky "bits shifted out" flag. It replaces the single-cycle left-only shifter in the ALU datapath wherever shift latency must be split across clock edges to meet timing. It sits between the ALU operand registers and the result mux.

---
 rtl/pipelined_shifter.sv | 97 +++++++++
 tb/tb_pipelined_shifter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: pipelined barrel shifter (SHL/SHR/SRA/ROL/ROR) with sticky shifted-out flag
// and valid/ready handshakes; shift levels are spread evenly over STAGES registers.
module pipelined_shifter #(
    parameter int BITS = 32,
    parameter int SHIFT_BITS = $clog2(BITS) + 1,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    input  logic [SHIFT_BITS-1:0] in_shift,
    input  logic [2:0]            in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-1:0]       out_data,
    output logic                  out_acc,
    output logic                  out_err
);
    localparam int DEPTH = $clog2(BITS);
    localparam int PER = (DEPTH + STAGES - 1) / STAGES;
    localparam logic [BITS-1:0] ONES = '1;
    localparam logic [2:0] SHL = 3'd0, SHR = 3'd1, SRA = 3'd2, ROL = 3'd3, ROR = 3'd4;

    logic adv;
    logic [BITS-1:0] pre_d;
    logic [DEPTH-1:0] pre_s;
    logic pre_a, pre_e;
    logic v_q [STAGES], v_n [STAGES];
    logic a_q [STAGES], a_n [STAGES];
    logic e_q [STAGES], e_n [STAGES];
    logic [BITS-1:0] d_q [STAGES], d_n [STAGES];
    logic [DEPTH-1:0] s_q [STAGES], s_n [STAGES];
    logic [2:0] o_q [STAGES], o_n [STAGES];

    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    assign out_valid = v_q[STAGES-1];
    assign out_data = d_q[STAGES-1];
    assign out_acc = a_q[STAGES-1];
    assign out_err = e_q[STAGES-1];

    // Illegal ops and out-of-range linear shifts are resolved up front, leaving a zero amount
    always_comb begin
        pre_e = in_op > ROR;
        pre_d = pre_e ? '0 : in_data;
        pre_s = pre_e ? '0 : in_shift[DEPTH-1:0];
        pre_a = 1'b0;
        if (!pre_e && |(in_shift >> DEPTH) && in_op <= SRA) begin
            pre_d = in_op == SRA ? {BITS{in_data[BITS-1]}} : '0;
            pre_s = '0;
            pre_a = |in_data;
        end
        for (int s = 0; s < STAGES; s++) begin
            v_n[s] = s == 0 ? in_valid : v_q[s == 0 ? 0 : s - 1];
            d_n[s] = s == 0 ? pre_d : d_q[s == 0 ? 0 : s - 1];
            s_n[s] = s == 0 ? pre_s : s_q[s == 0 ? 0 : s - 1];
            o_n[s] = s == 0 ? in_op : o_q[s == 0 ? 0 : s - 1];
            a_n[s] = s == 0 ? pre_a : a_q[s == 0 ? 0 : s - 1];
            e_n[s] = s == 0 ? pre_e : e_q[s == 0 ? 0 : s - 1];
            for (int j = 0; j < DEPTH; j++) begin
                if (j / PER == s && s_n[s][j]) begin
                    a_n[s] = a_n[s] | (o_n[s] == SHL ? |(d_n[s] & ~(ONES >> (1 << j))) :
                             (o_n[s] == SHR || o_n[s] == SRA) ? |(d_n[s] & ~(ONES << (1 << j))) : 1'b0);
                    d_n[s] = o_n[s] == SHL ? d_n[s] << (1 << j) :
                             o_n[s] == SHR ? d_n[s] >> (1 << j) :
                             o_n[s] == SRA ? (d_n[s] >> (1 << j)) | ({BITS{d_n[s][BITS-1]}} & ~(ONES >> (1 << j))) :
                             o_n[s] == ROL ? (d_n[s] << (1 << j)) | (d_n[s] >> (BITS - (1 << j))) :
                             (d_n[s] >> (1 << j)) | (d_n[s] << (BITS - (1 << j)));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= 1'b0;
                a_q[s] <= 1'b0;
                e_q[s] <= 1'b0;
                d_q[s] <= '0;
                s_q[s] <= '0;
                o_q[s] <= '0;
            end
        end else if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= v_n[s];
                a_q[s] <= a_n[s];
                e_q[s] <= e_n[s];
                d_q[s] <= d_n[s];
                s_q[s] <= s_n[s];
                o_q[s] <= o_n[s];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: drives STAGES=1,2,5 instances in parallel and scores every valid output
// against a 64-bit arithmetic reference model with per-instance expectation queues.
module tb_pipelined_shifter;
    typedef struct packed {logic [31:0] d; logic a; logic e;} exp_t;

    logic clk, clr, in_valid, out_ready;
    logic [31:0] in_data;
    logic [5:0] in_shift;
    logic [2:0] in_op;
    logic ir [3], ov [3], oa [3], oe [3];
    logic [31:0] od [3];
    exp_t sb [3][$];
    int checks, failures;

    for (genvar g = 0; g < 3; g++) begin : u
        pipelined_shifter #(.BITS(32), .STAGES(g == 0 ? 1 : g == 1 ? 2 : 5)) dut (
            .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(ir[g]),
            .in_data(in_data), .in_shift(in_shift), .in_op(in_op),
            .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]),
            .out_acc(oa[g]), .out_err(oe[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int st_of(int k);
        return k == 0 ? 1 : k == 1 ? 2 : 5;
    endfunction

    function automatic exp_t model(logic [31:0] d, logic [5:0] sh, logic [2:0] op);
        exp_t r;
        logic [63:0] x;
        int n;
        r = '0;
        n = int'(sh);
        if (op > 3'd4) r.e = 1'b1;
        else if (op <= 3'd2 && n >= 32) begin
            r.d = op == 3'd2 ? {32{d[31]}} : 32'h0;
            r.a = |d;
        end else if (op == 3'd0) begin
            x = {32'h0, d} << n;
            r.d = x[31:0];
            r.a = |x[63:32];
        end else if (op == 3'd1) begin
            x = {d, 32'h0} >> n;
            r.d = x[63:32];
            r.a = |x[31:0];
        end else if (op == 3'd2) begin
            x = $signed({d, 32'h0}) >>> n;
            r.d = x[63:32];
            r.a = |x[31:0];
        end else if (op == 3'd3) begin
            x = {d, d} << (n % 32);
            r.d = x[63:32];
        end else begin
            x = {d, d} >> (n % 32);
            r.d = x[31:0];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (clr) sb[k].delete();
            else begin
                if (ov[k]) begin
                    if (sb[k].size() == 0) chk($sformatf("unexpected_out_st%0d", st_of(k)), 1, 0);
                    else begin
                        e = sb[k][0];
                        chk($sformatf("out_st%0d", st_of(k)), {od[k], oa[k], oe[k]}, e);
                        if (out_ready) void'(sb[k].pop_front());
                    end
                end
                if (in_valid && ir[k]) sb[k].push_back(model(in_data, in_shift, in_op));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] sh, input logic [2:0] op);
        in_valid = 1'b1;
        in_data = d;
        in_shift = sh;
        in_op = op;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        clr = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_op = '0; out_ready = 1'b1;
        checks = 0; failures = 0;
        chk("pin_shl", model(32'h800000F1, 6'd4, 3'd0), {32'h00000F10, 2'b10});
        chk("pin_shr", model(32'h800000F1, 6'd4, 3'd1), {32'h0800000F, 2'b10});
        chk("pin_sra", model(32'h800000F1, 6'd4, 3'd2), {32'hF800000F, 2'b10});
        chk("pin_rol", model(32'h800000F1, 6'd4, 3'd3), {32'h00000F18, 2'b00});
        chk("pin_ror", model(32'h800000F1, 6'd4, 3'd4), {32'h1800000F, 2'b00});
        chk("pin_shl_oor", model(32'h80000000, 6'd33, 3'd0), {32'h0, 2'b10});
        chk("pin_sra_oor", model(32'h80000000, 6'd33, 3'd2), {32'hFFFFFFFF, 2'b10});
        chk("pin_rol_oor", model(32'h80000000, 6'd33, 3'd3), {32'h1, 2'b00});
        chk("pin_illegal", model(32'h12345678, 6'd3, 3'd6), {32'h0, 2'b01});
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_valid", ov[k], 0);
            chk("reset_data", od[k], 0);
            chk("reset_ready", ir[k], 1);
        end
        clr = 1'b0;
        #1;
        chk("ready_after_reset", ir[1], 1);

        in_valid = 1'b1; in_data = 32'h1; in_shift = 6'd4; in_op = 3'd0;
        tick();
        in_valid = 1'b0;
        for (int m = 0; m < 7; m++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                chk($sformatf("latency_st%0d_m%0d", st_of(k), m), ov[k], m == st_of(k) - 1);
            monitor();
            @(posedge clk);
            #1;
        end

        send(32'h800000F1, 6'd4, 3'd0);
        send(32'h800000F1, 6'd4, 3'd1);
        send(32'h800000F1, 6'd4, 3'd2);
        send(32'h800000F1, 6'd4, 3'd3);
        send(32'h800000F1, 6'd4, 3'd4);
        send(32'h80000000, 6'd33, 3'd0);
        send(32'h80000000, 6'd33, 3'd2);
        send(32'h80000000, 6'd33, 3'd3);
        send(32'h00000000, 6'd32, 3'd1);
        repeat (7) tick();

        send(32'hAAAA0001, 6'd1, 3'd0);
        send(32'hBBBB0002, 6'd2, 3'd1);
        in_valid = 1'b1; in_data = 32'hCCCC0003; in_shift = 6'd3; in_op = 3'd2;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", ir[1], 0);
            chk("stall_out_valid", ov[1], 1);
            monitor();
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("release_valid_%0d", i), ov[1], i < 3);
            monitor();
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        repeat (6) tick();

        send(32'h0000F00F, 6'd8, 3'd3);
        send(32'hDEADBEEF, 6'd5, 3'd6);
        send(32'h0000F00F, 6'd8, 3'd4);
        repeat (7) tick();

        send(32'h11111111, 6'd1, 3'd0);
        send(32'h22222222, 6'd2, 3'd1);
        clr = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk("clr_drop", ov[k], 0);
        repeat (2) tick();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) chk("clr_quiet", ov[k], 0);
            monitor();
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 400; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_data = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 1, 31'h0} : $urandom;
            in_shift = 6'($urandom_range(0, 63));
            in_op = 3'($urandom_range(0, 7));
            out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        for (int k = 0; k < 3; k++) chk($sformatf("drained_st%0d", st_of(k)), sb[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
